// File: rtl/sd_arbiter.sv
// Two-client arbiter for the MiST I/O block's sector-level SD channel.
// Runs one sector transaction at a time (grant, request, transfer, done) with round-robin fairness.
module sd_arbiter #(
  parameter logic [23:0] TIMEOUT = 24'd10000000
) (
  input  logic        clk_sys,
  input  logic        reset_n,

  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic        sd_buff_wr,
  output logic [7:0]  sd_buff_din,

  input  logic [31:0] c0_lba,
  input  logic        c0_rd,
  input  logic        c0_wr,
  output logic        c0_ack,
  output logic        c0_done,
  output logic        c0_err,
  output logic        c0_buff_wr,
  input  logic [7:0]  c0_buff_din,

  input  logic [31:0] c1_lba,
  input  logic        c1_rd,
  input  logic        c1_wr,
  output logic        c1_ack,
  output logic        c1_done,
  output logic        c1_err,
  output logic        c1_buff_wr,
  input  logic [7:0]  c1_buff_din
);

  localparam int CNT_W = $clog2(32'(TIMEOUT) + 32'd1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(32'(TIMEOUT) - 32'd1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic             grant_q, grant_d;
  logic             ptr_q, ptr_d;
  logic [1:0]       rel_q, rel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      lba_q, lba_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic [1:0]       ack_q, ack_d;
  logic [1:0]       done_q, done_d;
  logic [1:0]       err_q, err_d;

  logic [1:0]       req;
  logic [1:0]       elig;
  logic             pick;
  logic             op_wr;
  logic             in_xfer;

  assign req  = {c1_rd | c1_wr, c0_rd | c0_wr};
  assign elig = rel_q & req;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      ptr_q   <= 1'b0;
      rel_q   <= 2'b11;
      cnt_q   <= '0;
      lba_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ack_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      rel_q   <= rel_d;
      cnt_q   <= cnt_d;
      lba_q   <= lba_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    lba_d   = lba_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    ack_d   = ack_q;
    done_d  = '0;
    err_d   = '0;
    pick    = 1'b0;
    op_wr   = 1'b0;

    case (state_q)
      IDLE: begin
        if (elig != 2'b00) begin
          // With both eligible the pointer decides; otherwise elig[1] names the lone requester.
          pick    = (elig == 2'b11) ? ptr_q : elig[1];
          op_wr   = pick ? c1_wr : c0_wr;
          grant_d = pick;
          lba_d   = pick ? c1_lba : c0_lba;
          wr_d    = op_wr;
          rd_d    = ~op_wr;
          cnt_d   = '0;
          state_d = REQ;
        end
      end

      REQ: begin
        if (sd_ack) begin
          rd_d           = 1'b0;
          wr_d           = 1'b0;
          ack_d[grant_q] = 1'b1;
          state_d        = XFER;
        end else if (cnt_q == CNT_LAST) begin
          rd_d            = 1'b0;
          wr_d            = 1'b0;
          done_d[grant_q] = 1'b1;
          err_d[grant_q]  = 1'b1;
          state_d         = DONE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      XFER: begin
        if (!sd_ack) begin
          ack_d           = '0;
          done_d[grant_q] = 1'b1;
          state_d         = DONE;
        end
      end

      DONE: begin
        ptr_d   = ~grant_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // A served client must drop its request before it becomes eligible again.
  always_comb begin
    rel_d = rel_q;
    if (state_q == DONE && !grant_q) rel_d[0] = 1'b0;
    if (state_q == DONE &&  grant_q) rel_d[1] = 1'b0;
    if (!req[0]) rel_d[0] = 1'b1;
    if (!req[1]) rel_d[1] = 1'b1;
  end

  assign in_xfer     = (state_q == XFER);
  assign c0_buff_wr  = in_xfer & ~grant_q & sd_buff_wr;
  assign c1_buff_wr  = in_xfer &  grant_q & sd_buff_wr;
  assign sd_buff_din = !in_xfer ? 8'h00 : (grant_q ? c1_buff_din : c0_buff_din);

  assign sd_lba  = lba_q;
  assign sd_rd   = rd_q;
  assign sd_wr   = wr_q;
  assign c0_ack  = ack_q[0];
  assign c1_ack  = ack_q[1];
  assign c0_done = done_q[0];
  assign c1_done = done_q[1];
  assign c0_err  = err_q[0];
  assign c1_err  = err_q[1];

endmodule

// File: doc/sd_arbiter.md
Name: sd_arbiter

Overview:
- Shares the single sector-level SD channel of the MiST I/O block (sd_lba/sd_rd/sd_wr/sd_ack plus the 512-byte buffer port) between two SD clients, for example DivMMC and +3/TR-DOS disk emulation.
- Sequences one sector transaction at a time: grant, request, transfer, done.
- Routes the buffer write strobe and write-back data to the granted client only.
- Sits between the I/O block and the disk controllers in clk_sys domain.

Parameters:
- TIMEOUT, 24'd10000000: clk_sys cycles allowed in REQ for sd_ack to rise before abort.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- sd_lba  out  32  LBA to I/O block
- sd_rd  out  1  sector read request to I/O block
- sd_wr  out  1  sector write request to I/O block
- sd_ack  in  1  transfer-in-progress from I/O block
- sd_buff_wr  in  1  buffer byte strobe from I/O block
- sd_buff_din  out  8  write-back byte to I/O block
- c0_lba  in  32  client 0 LBA
- c0_rd  in  1  client 0 read request (level)
- c0_wr  in  1  client 0 write request (level)
- c0_ack  out  1  client 0 transfer active
- c0_done  out  1  client 0 completion pulse
- c0_err  out  1  client 0 timeout flag, valid with c0_done
- c0_buff_wr  out  1  gated buffer strobe for client 0
- c0_buff_din  in  8  client 0 write-back byte
- c1_*: identical set for client 1

Behaviour:
- Clock and reset: one clock, clk_sys; reset is asynchronous and active-low (reset_n). All outputs are registered except cN_buff_wr and sd_buff_din.
- Reset values: every output 0, state IDLE, priority pointer on client 0, both release flags 1.
- Sharing: sd_buff_addr and sd_buff_dout are wired from the I/O block directly to both clients and do not pass through this block.
- Eligibility: client N is eligible when rel_N=1 and (cN_rd or cN_wr) is high.
  - On DONE, rel_N is cleared.
  - rel_N is set again in any cycle where cN_rd=cN_wr=0.
- State IDLE:
  - If both clients are eligible, grant the one the pointer names. Otherwise grant the single eligible client.
  - Latch cN_lba and the op into registers. If rd and wr are both high, wr wins.
  - Go to REQ. sd_rd/sd_wr rise on the cycle after the request is seen (latency 1).
- State REQ:
  - Hold sd_lba and the requested sd_rd/sd_wr high; the timeout counter increments.
  - When sd_ack=1: drop sd_rd/sd_wr on the next edge, set cN_ack=1, go to XFER.
  - When the counter reaches TIMEOUT-1 with sd_ack=0: drop the request, go to DONE with err=1.
- State XFER:
  - cN_ack=1; cN_buff_wr = sd_buff_wr for the granted client; the other client sees 0.
  - sd_buff_din = granted client's cN_buff_din (combinational mux).
  - When sd_ack=0: cN_ack=0, go to DONE.
- State DONE (one cycle):
  - cN_done=1 for exactly one cycle; cN_err=1 in that cycle if the transaction timed out, 0 otherwise.
  - Pointer moves to the other client; rel_N cleared; go to IDLE.
- Outside XFER: both cN_buff_wr are 0 and sd_buff_din is 0.
- Unsolicited sd_ack in IDLE or DONE: ignored, nothing routed, no state change. Example: the I/O block's config transfer.
- Request withdrawn in REQ before sd_ack: the transaction continues to completion. The client must not withdraw.
- sd_lba latched at grant: later changes to cN_lba have no effect until the next grant.
- Timeout counter width is $clog2(TIMEOUT+1) bits. The counter clears on entering REQ and does not wrap.
- Reset mid-transfer: all state returns to reset values immediately. The I/O block may complete the sector; strobes are not routed and no done is issued.

Test Plan:
- Single read: c0_rd=1, c0_lba=32'h00001234; I/O block asserts sd_ack after 5 cycles and 512 strobes -> sd_rd high from the cycle after request until one cycle after ack, sd_lba=32'h1234, c0_buff_wr toggles 512 times, c1_buff_wr stays 0, one c0_done with c0_err=0.
- Contention: c0_rd and c1_wr rise in the same cycle after reset -> c0 served first, then c1 with sd_wr=1 and sd_buff_din following c1_buff_din; exactly one done each.
- Fairness: both clients hold requests continuously and drop each after its done -> grants alternate c0,c1,c0,c1; a client holding rd without release is never re-granted.
- Timeout: TIMEOUT=16, c1_rd=1, sd_ack never rises -> sd_rd drops after 16 REQ cycles, c1_done=1 and c1_err=1 in the same cycle, arbiter back in IDLE.
- Unsolicited ack: sd_ack pulses with 10 sd_buff_wr strobes while IDLE -> both cN_buff_wr and cN_ack stay 0, no done.
- Reset mid-XFER: reset_n low after 100 strobes -> all outputs 0 asynchronously; after release, a new c0 request is granted normally.
